// File: rtl/ex_flags_stage.sv
`timescale 1ns/1ps
// Execute-stage flag unit: evaluates condition codes against the committed NZCV,
// updates the status register and buffers results in a 2-entry writeback FIFO.
module ex_flags_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ALU_out,
    input  logic [31:0] flags,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_cond,
    input  logic        in_setf,
    input  logic        flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_rd,
    output logic        wb_en,
    output logic [31:0] status_reg,
    output logic [15:0] retired
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned RD_W   = 4;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned RET_W  = 16;

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [RD_W-1:0]   r_rd   [DEPTH];
    logic              r_pass [DEPTH];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [3:0]        r_status;
    logic [RET_W-1:0]  r_retired;

    logic w_n, w_z, w_c, w_v;
    logic w_pass;
    logic w_accept;
    logic w_pop;
    logic w_unused_flags;

    assign w_unused_flags = ^flags[27:0];
    assign {w_n, w_z, w_c, w_v} = r_status;

    assign in_ready   = (r_count < CNT_W'(DEPTH));
    assign wb_valid   = (r_count != '0);
    assign wb_data    = r_data[r_rd_ptr];
    assign wb_rd      = r_rd[r_rd_ptr];
    assign wb_en      = r_pass[r_rd_ptr];
    assign status_reg = {r_status, 28'h0000000};
    assign retired    = r_retired;

    assign w_accept = in_valid && in_ready && !flush;
    assign w_pop    = wb_valid && wb_ready && !flush;

    // Condition evaluated against the status value before this cycle's update
    always_comb begin
        w_pass = 1'b0;
        case (in_cond)
            4'h0:    w_pass = w_z;
            4'h1:    w_pass = !w_z;
            4'h2:    w_pass = w_c;
            4'h3:    w_pass = !w_c;
            4'h4:    w_pass = w_n;
            4'h5:    w_pass = !w_n;
            4'h6:    w_pass = w_v;
            4'h7:    w_pass = !w_v;
            4'h8:    w_pass = w_c && !w_z;
            4'h9:    w_pass = !w_c || w_z;
            4'hA:    w_pass = (w_n == w_v);
            4'hB:    w_pass = (w_n != w_v);
            4'hC:    w_pass = !w_z && (w_n == w_v);
            4'hD:    w_pass = w_z || (w_n != w_v);
            4'hE:    w_pass = 1'b1;
            default: w_pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
        end else if (w_accept && w_pass && in_setf) begin
            r_status <= flags[31:28];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_rd[i]   <= '0;
                r_pass[i] <= 1'b0;
            end
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= '0;
            r_retired <= '0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_accept) begin
                r_data[r_wr_ptr] <= ALU_out;
                r_rd[r_wr_ptr]   <= in_rd;
                r_pass[r_wr_ptr] <= w_pass;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                if (r_pass[r_rd_ptr]) begin
                    r_retired <= r_retired + RET_W'(1);
                end
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_flags_stage.sv
`timescale 1ns/1ps
// Self-checking bench for ex_flags_stage: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_ex_flags_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ALU_out;
    logic [31:0] flags;
    logic [3:0]  in_rd;
    logic [3:0]  in_cond;
    logic        in_setf;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_en;
    logic [31:0] status_reg;
    logic [15:0] retired;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  rd;
        logic        en;
    } entry_t;

    entry_t      m_q[$];
    logic [3:0]  m_status;
    logic [15:0] m_retired;

    localparam logic [3:0] C_EQ = 4'h0, C_NE = 4'h1, C_GE = 4'hA, C_LT = 4'hB, C_AL = 4'hE;

    ex_flags_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_out(ALU_out), .flags(flags), .in_rd(in_rd), .in_cond(in_cond),
        .in_setf(in_setf), .flush(flush), .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en),
        .status_reg(status_reg), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] s);
        bit n, z, cf, v;
        {n, z, cf, v} = s;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cf;
            4'h3: return !cf;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cf && !z;
            4'h9: return !cf || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drv(input bit v, input logic [31:0] d, input logic [3:0] c,
                       input bit s, input logic [31:0] f);
        in_valid = v;
        ALU_out  = d;
        in_rd    = d[3:0];
        in_cond  = c;
        in_setf  = s;
        flags    = f;
    endtask

    // Advance one clock edge and apply the same edge to the model
    task automatic step();
        bit acc, pop;
        entry_t e;
        acc = in_valid && (m_q.size() < 2) && !flush;
        pop = (m_q.size() > 0) && wb_ready && !flush;
        e.d = ALU_out;
        e.rd = in_rd;
        e.en = cond_pass(in_cond, m_status);
        @(posedge clk);
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop) begin
                if (m_q[0].en) m_retired = m_retired + 16'd1;
                void'(m_q.pop_front());
            end
            if (acc) begin
                m_q.push_back(e);
                if (e.en && in_setf) m_status = flags[31:28];
            end
        end
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        flush = 1'b0;
        wb_ready = 1'b0;
        drv(0, 0, C_AL, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete();
        m_status = 4'h0;
        m_retired = 16'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        wb_ready = 1'b1;
        drv(1, 32'hDEAD_BEEF, C_AL, 1, 32'hF000_0000);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        n_cmp++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
        n_cmp++; if (wb_rd !== 4'h0) begin n_fail++; $display("FAIL reset_wb_rd got %h want 0", wb_rd); end
        n_cmp++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en got %b want 0", wb_en); end
        n_cmp++; if (status_reg !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h want 0", status_reg); end
        n_cmp++; if (retired !== 16'h0) begin n_fail++; $display("FAIL reset_retired got %h want 0", retired); end
        apply_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        apply_reset();
        wb_ready = 1'b1;
        drv(1, 32'd4, C_AL, 1, 32'h0);
        step();
        drv(0, 0, C_AL, 0, 0);
        n_cmp++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL basic_wb_valid got %b want 1", wb_valid); end
        n_cmp++; if (wb_data !== 32'd4) begin n_fail++; $display("FAIL basic_wb_data got %h want 4", wb_data); end
        n_cmp++; if (wb_en !== 1'b1) begin n_fail++; $display("FAIL basic_wb_en got %b want 1", wb_en); end
        n_cmp++; if (status_reg !== 32'h0) begin n_fail++; $display("FAIL basic_status got %h want 0", status_reg); end
        step();
        n_cmp++; if (retired !== 16'd1) begin n_fail++; $display("FAIL basic_retired got %0d want 1", retired); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %b want 0", wb_valid); end
    endtask

    task automatic test_cond_eq_ne();
        apply_reset();
        wb_ready = 1'b1;
        drv(1, 32'h11, C_AL, 1, 32'h4000_0000);
        step();
        drv(1, 32'h22, C_EQ, 0, 32'h0);
        step();
        n_cmp++; if (wb_data !== 32'h22) begin n_fail++; $display("FAIL eq_head got %h want 22", wb_data); end
        n_cmp++; if (wb_en !== 1'b1) begin n_fail++; $display("FAIL eq_wb_en got %b want 1", wb_en); end
        n_cmp++; if (status_reg !== 32'h4000_0000) begin n_fail++; $display("FAIL eq_status got %h want 40000000", status_reg); end
        drv(1, 32'h33, C_NE, 0, 32'h0);
        step();
        n_cmp++; if (wb_data !== 32'h33) begin n_fail++; $display("FAIL ne_head got %h want 33", wb_data); end
        n_cmp++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL ne_wb_en got %b want 0", wb_en); end
        n_cmp++; if (retired !== 16'd2) begin n_fail++; $display("FAIL ne_retired_pre got %0d want 2", retired); end
        drv(0, 0, C_AL, 0, 0);
        step();
        n_cmp++; if (retired !== 16'd2) begin n_fail++; $display("FAIL ne_retired_post got %0d want 2", retired); end
        n_cmp++; if (status_reg !== 32'h4000_0000) begin n_fail++; $display("FAIL ne_status got %h want 40000000", status_reg); end
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL ne_drain got %b want 0", wb_valid); end
    endtask

    task automatic test_ge_lt();
        apply_reset();
        wb_ready = 1'b1;
        drv(1, 32'h1, C_AL, 1, 32'h9000_0000);
        step();
        drv(1, 32'h2, C_GE, 0, 32'h0);
        step();
        n_cmp++; if (wb_en !== 1'b1 || wb_data !== 32'h2) begin n_fail++; $display("FAIL ge_pass got en=%b d=%h want en=1 d=2", wb_en, wb_data); end
        drv(1, 32'h3, C_LT, 1, 32'h0);
        step();
        n_cmp++; if (wb_en !== 1'b0 || wb_data !== 32'h3) begin n_fail++; $display("FAIL lt_fail got en=%b d=%h want en=0 d=3", wb_en, wb_data); end
        drv(0, 0, C_AL, 0, 0);
        step();
        n_cmp++; if (status_reg !== 32'h9000_0000) begin n_fail++; $display("FAIL lt_status got %h want 90000000", status_reg); end
        n_cmp++; if (retired !== 16'd2) begin n_fail++; $display("FAIL lt_retired got %0d want 2", retired); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        bit acc;
        apply_reset();
        wb_ready = 1'b0;
        drv(1, 32'd1, C_AL, 0, 0);
        step();
        drv(1, 32'd2, C_AL, 0, 0);
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
        drv(1, 32'd3, C_AL, 0, 0);
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_held_ready got %b want 0", in_ready); end
        n_cmp++; if (wb_data !== 32'd1 || wb_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head_stable got v=%b d=%h want v=1 d=1", wb_valid, wb_data); end
        wb_ready = 1'b1;
        for (int i = 0; i < 10 && got.size() < 3; i++) begin
            if (wb_valid && wb_ready) got.push_back(wb_data);
            acc = in_valid && in_ready;
            step();
            if (acc) drv(0, 0, C_AL, 0, 0);
        end
        n_cmp++;
        if (got.size() != 3) begin
            n_fail++; $display("FAIL bp_order_count got %0d want 3", got.size());
        end else if (got[0] !== 32'd1 || got[1] !== 32'd2 || got[2] !== 32'd3) begin
            n_fail++; $display("FAIL bp_order got %0d,%0d,%0d want 1,2,3", got[0], got[1], got[2]);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        wb_ready = 1'b0;
        drv(1, 32'd5, C_AL, 1, 32'h3000_0000);
        step();
        drv(1, 32'd6, C_AL, 0, 0);
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full got %b want 0", in_ready); end
        flush = 1'b1;
        wb_ready = 1'b1;
        drv(1, 32'd7, C_AL, 1, 32'h8000_0000);
        step();
        flush = 1'b0;
        wb_ready = 1'b0;
        drv(0, 0, C_AL, 0, 0);
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wb_valid got %b want 0", wb_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", in_ready); end
        n_cmp++; if (status_reg !== 32'h3000_0000) begin n_fail++; $display("FAIL flush_status got %h want 30000000", status_reg); end
        n_cmp++; if (retired !== 16'd0) begin n_fail++; $display("FAIL flush_retired got %0d want 0", retired); end
        step();
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got %b want 0", wb_valid); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        wb_ready = 1'b0;
        drv(1, 32'hA5, C_AL, 1, 32'hA000_0000);
        step();
        drv(1, 32'h5A, C_AL, 0, 0);
        step();
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL arst_wb_valid got %b want 0", wb_valid); end
        n_cmp++; if (status_reg !== 32'h0) begin n_fail++; $display("FAIL arst_status got %h want 0", status_reg); end
        n_cmp++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL arst_wb_data got %h want 0", wb_data); end
        wb_ready = 1'b1;
        drv(1, 32'h77, C_AL, 1, 32'hF000_0000);
        @(posedge clk);
        #1;
        n_cmp++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL arst_no_accept got %b want 0", wb_valid); end
        n_cmp++; if (status_reg !== 32'h0) begin n_fail++; $display("FAIL arst_no_setf got %h want 0", status_reg); end
        apply_reset();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            drv(($urandom_range(0, 3) != 0), $urandom(), 4'($urandom_range(0, 15)),
                $urandom_range(0, 1) == 1, $urandom());
            wb_ready = ($urandom_range(0, 1) == 1);
            flush = ($urandom_range(0, 15) == 0);
            n_cmp++; if (in_ready !== (m_q.size() < 2)) begin n_fail++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", i, in_ready, m_q.size() < 2); end
            n_cmp++; if (wb_valid !== (m_q.size() > 0)) begin n_fail++; $display("FAIL rnd_wb_valid cyc %0d got %b want %b", i, wb_valid, m_q.size() > 0); end
            if (m_q.size() > 0) begin
                n_cmp++;
                if (wb_data !== m_q[0].d || wb_rd !== m_q[0].rd || wb_en !== m_q[0].en) begin
                    n_fail++; $display("FAIL rnd_head cyc %0d got %h/%h/%b want %h/%h/%b", i, wb_data, wb_rd, wb_en, m_q[0].d, m_q[0].rd, m_q[0].en);
                end
            end
            n_cmp++; if (status_reg !== {m_status, 28'h0}) begin n_fail++; $display("FAIL rnd_status cyc %0d got %h want %h", i, status_reg, {m_status, 28'h0}); end
            n_cmp++; if (retired !== m_retired) begin n_fail++; $display("FAIL rnd_retired cyc %0d got %0d want %0d", i, retired, m_retired); end
            step();
        end
        flush = 1'b0;
        drv(0, 0, C_AL, 0, 0);
    endtask

    initial begin
        m_status = 4'h0;
        m_retired = 16'h0;
        test_reset();
        test_basic();
        test_cond_eq_ne();
        test_ge_lt();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
